// File: rtl/dm_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dm_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BYTE_LANES = DATA_WIDTH / 8;

    // Active-low byte enables: all ones means no lane is written.
    localparam logic [BYTE_LANES-1:0] WEB_ALL_OFF = '1;

    typedef logic [DATA_WIDTH-1:0] dm_word_t;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE
    } dm_acc_e;

endpackage

// File: rtl/dm_sram_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
interface dm_sram_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14
) ();

    logic                    dm_cs;
    logic [DATA_WIDTH/8-1:0] dm_web;
    logic [ADDR_WIDTH-1:0]   dm_addr;
    logic [DATA_WIDTH-1:0]   dm_di;
    logic [DATA_WIDTH-1:0]   dm_do;
    logic                    dm_rvalid;

    modport master (
        output dm_cs,
        output dm_web,
        output dm_addr,
        output dm_di,
        input  dm_do,
        input  dm_rvalid
    );

    modport slave (
        input  dm_cs,
        input  dm_web,
        input  dm_addr,
        input  dm_di,
        output dm_do,
        output dm_rvalid
    );

endinterface

// File: rtl/dm_rd_pipe.sv
// READ_LAT-deep shift of {valid, data}. Data registers only load behind a valid
// bit, so the output word holds its last valid value while no read returns.
module dm_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [READ_LAT-1:0]   r_valid;
    logic [DATA_WIDTH-1:0] r_data [READ_LAT];

    // Shift valid every cycle; move data only where a valid bit travels with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < int'(READ_LAT); i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_valid[READ_LAT-1];
    assign o_data  = r_data[READ_LAT-1];

endmodule

// File: rtl/dm_sram_responder.sv
// Single-port data memory for the MEM stage: byte-lane stores and fixed-latency
// full-word loads. The array itself is never reset.
module dm_sram_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned READ_LAT   = 1
) (
    input logic                 clk,
    input logic                 rst,
    dm_sram_responder_if.slave  bus
);

    import dm_pkg::*;

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    dm_acc_e               w_acc;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_valid;

    // Classify the access presented this cycle; chip select gates everything.
    always_comb begin
        w_acc = ACC_IDLE;
        if (bus.dm_cs) begin
            w_acc = (&bus.dm_web) ? ACC_READ : ACC_WRITE;
        end
    end

    // Byte-lane store; lanes with web high keep their old contents.
    always_ff @(posedge clk) begin
        if (w_acc == ACC_WRITE) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (!bus.dm_web[i]) begin
                    r_mem[bus.dm_addr][i*8 +: 8] <= bus.dm_di[i*8 +: 8];
                end
            end
        end
    end

    // The word is captured into the pipe at the accepting edge, so a later
    // write to the same address cannot disturb a read already in flight.
    assign w_rd_word  = r_mem[bus.dm_addr];
    assign w_rd_valid = (w_acc == ACC_READ);

    dm_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .READ_LAT   (READ_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_valid),
        .i_data  (w_rd_word),
        .o_valid (bus.dm_rvalid),
        .o_data  (bus.dm_do)
    );

    // Unknown chip select or byte enables are a protocol error from the MEM stage.
    a_no_x_ctrl : assert property (
        @(posedge clk) disable iff (!rst) !$isunknown({bus.dm_cs, bus.dm_web})
    );

endmodule

// File: tb/tb_dm_sram_responder.sv
// Scoreboarded bench driving identical traffic into READ_LAT = 1, 2 and 3 instances.
module tb_dm_sram_responder;

    import dm_pkg::*;

    localparam int unsigned AW = 14;
    localparam int NDUT = 3;

    typedef struct {
        dm_word_t data;
        int       due;
    } exp_t;

    logic                  clk  = 1'b0;
    logic                  rst  = 1'b1;
    logic                  cs   = 1'b0;
    logic [BYTE_LANES-1:0] web  = WEB_ALL_OFF;
    logic [AW-1:0]         addr = '0;
    dm_word_t              di   = '0;

    logic     w_rv [NDUT];
    dm_word_t w_do [NDUT];

    int       cyc      = 0;
    int       n_checks = 0;
    int       n_pass   = 0;
    exp_t     exp_q [NDUT][$];
    dm_word_t last_do [NDUT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dm_sram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

        assign bus.dm_cs   = cs;
        assign bus.dm_web  = web;
        assign bus.dm_addr = addr;
        assign bus.dm_di   = di;
        assign w_rv[g]     = bus.dm_rvalid;
        assign w_do[g]     = bus.dm_do;

        dm_sram_responder #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (AW),
            .READ_LAT   (g + 1)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: runs on the falling edge, independent of the stimulus process.
    task automatic mon(input int k, input logic v, input dm_word_t d);
        exp_t e;
        if (!rst) begin
            chk($sformatf("reset_do_lat%0d", k + 1), d, 32'h0);
            chk($sformatf("reset_rvalid_lat%0d", k + 1), {31'b0, v}, 32'h0);
            exp_q[k].delete();
            last_do[k] = '0;
        end else if (v) begin
            if (exp_q[k].size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rvalid_lat%0d: got rvalid=1 do=%h, expected rvalid=0",
                         k + 1, d);
            end else begin
                e = exp_q[k].pop_front();
                chk($sformatf("rdata_lat%0d", k + 1), d, e.data);
                chk($sformatf("rcycle_lat%0d", k + 1), cyc, e.due);
                last_do[k] = e.data;
            end
        end else begin
            chk($sformatf("hold_do_lat%0d", k + 1), d, last_do[k]);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) mon(k, w_rv[k], w_do[k]);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cs  = 1'b0;
            web = WEB_ALL_OFF;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input dm_word_t d, input logic [3:0] w);
        @(posedge clk);
        #1;
        cs   = 1'b1;
        web  = w;
        addr = a;
        di   = d;
    endtask

    // Issue a read in cycle cyc; instance k must answer in cycle cyc + k + 1.
    task automatic rd(input logic [AW-1:0] a, input dm_word_t exp);
        @(posedge clk);
        #1;
        cs   = 1'b1;
        web  = WEB_ALL_OFF;
        addr = a;
        di   = 32'h0;
        for (int k = 0; k < NDUT; k++) exp_q[k].push_back('{data: exp, due: cyc + k + 1});
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) last_do[k] = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        // Full-word store then load.
        wr(14'h0010, 32'hDEADBEEF, 4'b0000);
        rd(14'h0010, 32'hDEADBEEF);
        idle(4);

        // Byte then half-word stores merged into a preloaded word.
        wr(14'h0020, 32'h11223344, 4'b0000);
        wr(14'h0020, 32'h000000AA, 4'b1110);
        wr(14'h0020, 32'hBBBB0000, 4'b0011);
        rd(14'h0020, 32'hBBBB33AA);
        idle(4);

        // Back-to-back reads return in order on consecutive cycles.
        wr(14'h0001, 32'h00000001, 4'b0000);
        wr(14'h0002, 32'h00000002, 4'b0000);
        wr(14'h0003, 32'h00000003, 4'b0000);
        rd(14'h0001, 32'h00000001);
        rd(14'h0002, 32'h00000002);
        rd(14'h0003, 32'h00000003);
        idle(4);

        // Write right behind an in-flight read; old data returns, then new.
        wr(14'h0005, 32'h00000055, 4'b0000);
        idle(1);
        rd(14'h0005, 32'h00000055);
        wr(14'h0005, 32'h00000066, 4'b0000);
        idle(3);
        rd(14'h0005, 32'h00000066);
        idle(4);

        // Top address, partial store on upper lane only.
        wr(14'h3FFF, 32'hA5A5A5A5, 4'b0000);
        wr(14'h3FFF, 32'h5A000000, 4'b0111);
        rd(14'h3FFF, 32'h5AA5A5A5);
        idle(4);

        // Reset with a read in flight: discarded, array preserved.
        wr(14'h0007, 32'hCAFEF00D, 4'b0000);
        idle(1);
        rd(14'h0007, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cs  = 1'b0;
        web = WEB_ALL_OFF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(5);
        rd(14'h0007, 32'hCAFEF00D);
        idle(5);

        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("drained_lat%0d", k + 1), exp_q[k].size(), 32'h0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/dm_sram_responder.md
Name: dm_sram_responder

Overview:
- Data-memory responder for the pipeline's MEM stage. Accepts chip select, active-low byte write enables, word address and write data; services stores by byte lane and loads with a fixed, parameterised read latency.
- Single-port, synchronous SRAM behaviour: one access per cycle, either read or write.
- Returns the full 32-bit word. Load sign/zero extension and byte/half selection are done by the MEM/WB side, not here.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 14, word-address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LAT, 1, cycles from accepted read to valid data; legal range 1..3.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- dm_cs  input  1  chip select; access accepted only when high
- dm_web  input  DATA_WIDTH/8  active-low byte write enables; bit i covers data[8i+7:8i]
- dm_addr  input  ADDR_WIDTH  word address
- dm_di  input  DATA_WIDTH  store data, already lane-aligned by MEM stage
- dm_do  output  DATA_WIDTH  load data
- dm_rvalid  output  1  one-cycle pulse, dm_do carries data for a read issued READ_LAT cycles earlier

Behaviour:
- Reset (rst low, async):
  - dm_do = 0, dm_rvalid = 0, all read-pipeline valid bits cleared.
  - Memory array is not reset; contents persist across reset.
- Access classification at each rising edge, dm_cs=1:
  - Any dm_web bit 0: write cycle.
  - dm_web all 1s: read cycle.
  - dm_cs=0: idle; dm_web, dm_addr and dm_di are ignored.
- Write:
  - At the edge, for each lane i with dm_web[i]=0, mem[dm_addr][lane i] <= dm_di[lane i]; other lanes unchanged.
  - No read data produced; dm_rvalid does not pulse for this access; dm_do holds.
- Read:
  - mem[dm_addr] is sampled at the accepting edge.
  - Data is presented on dm_do, with dm_rvalid=1, exactly READ_LAT edges later.
  - READ_LAT=1: data is valid in the cycle after the request.
- Pipeline:
  - READ_LAT-deep shift of {valid, data}.
  - Fully pipelined: back-to-back reads on consecutive cycles give back-to-back dm_rvalid pulses in order.
  - No backpressure.
- dm_do hold: when the pipeline output is not valid, dm_do keeps its last valid value (no return to 0).
- Read-after-write:
  - A read to an address written at edge N, issued at edge N+1 or later, returns the new data.
  - No forwarding is needed, since write and read cannot share an edge.
- Interleaving: a write issued while earlier reads are in flight does not disturb their data; each read's data is captured at its own sampling edge.
- Reset mid-operation: in-flight reads are discarded; no dm_rvalid for them after rst releases.
- Address: dm_addr is exactly ADDR_WIDTH bits; every value maps to a location, with no wrap or out-of-range case.
- X handling: dm_cs=X or dm_web=X is a protocol error; the assertion module flags it. Design behaviour in that case is unspecified.

Decomposition:
- Shared package dm_pkg:
  - DATA_WIDTH and BYTE_LANES constants.
  - WEB_ALL_OFF = all-ones constant.
  - Typedef dm_word_t.
  - Enum dm_acc_e {ACC_IDLE, ACC_READ, ACC_WRITE} used by the access classifier and the bench.
- One sub-module dm_rd_pipe: parameterised READ_LAT shift register of {valid, data} with async active-low clear. The top instantiates the array plus dm_rd_pipe.

Test Plan:
- Reset:
  - Stimulus: rst low for 3 cycles, then high, dm_cs=0.
  - Response: dm_do=0x00000000 and dm_rvalid=0 throughout; no pulses after release.
- Full-word store then load, READ_LAT=1:
  - Stimulus: write 0xDEADBEEF to addr 0x0010 with web=4'b0000; next cycle read addr 0x0010.
  - Response: one cycle after the read, dm_rvalid=1 and dm_do=0xDEADBEEF.
- Byte and half stores:
  - Stimulus: preload 0x11223344 at 0x0020; write dm_di=0x000000AA with web=4'b1110; then dm_di=0xBBBB0000 with web=4'b0011; read 0x0020.
  - Response: dm_do=0xBBBB33AA.
- Latency and back-to-back, READ_LAT=3:
  - Stimulus: reads to 0x0001, 0x0002, 0x0003 on consecutive cycles, preloaded with 1, 2, 3.
  - Response: dm_rvalid high for 3 consecutive cycles starting 3 cycles after the first read, data 1, 2, 3 in order.
- Write interleaved with in-flight read, READ_LAT=2:
  - Stimulus: read 0x0005 (holds 0x55); next cycle write 0x0005 with 0x66.
  - Response: read returns 0x55; a later read returns 0x66; dm_do holds 0x55 between the two reads.
- Reset mid-flight, READ_LAT=3:
  - Stimulus: issue a read; assert rst one cycle later.
  - Response: dm_do=0 and dm_rvalid=0 immediately; no pulse after release; array contents preserved, so a re-read returns the original data.
